ch3_scan_mux: RTL
=================

# ch3_scan_mux

Parametrised N-channel, W-bit registered multiplexer with manual select and auto-scan modes. It succeeds the fixed 4:1 combinational mux. Auto mode steps round-robin through enabled channels, holding each for a programmable dwell, and skips masked channels. It sits between parallel sensor/data lanes and a single downstream consumer, and tags every output sample with its source channel and a valid flag.

## Interface
- N, 4, number of input channels (2..16)
- W, 1, data width per channel
- DWELL_W, 4, width of dwell-count input
- SEL_W, $clog2(N), select/channel-index width (derived)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- I  in  N*W  channel data, channel k at I[k*W +: W]
- S  in  SEL_W  manual channel select
- MODE  in  1  0 = manual, 1 = auto-scan
- EN_MASK  in  N  auto-mode channel enable, bit k = channel k
- DWELL  in  DWELL_W  auto mode: cycles per channel = DWELL+1
- Z  out  W  registered selected data
- ZSEL  out  SEL_W  channel index that produced Z
- ZV  out  1  Z valid
- STEP  out  1  one-cycle pulse in the cycle ZSEL changes in auto mode

## Operation
- States: IDLE, MANUAL, SCAN.
- Reset, and async assertion of RST at any time: state IDLE, Z=0, ZSEL=0, ZV=0, STEP=0, dwell counter CNT=0.
- Out of reset, the state is chosen each cycle from MODE and EN_MASK:
  - MODE=0 -> MANUAL.
  - MODE=1 with EN_MASK≠0 -> SCAN.
  - MODE=1 with EN_MASK=0 -> IDLE.
- MANUAL:
  - Each cycle ZSEL<=S, Z<=I[S], ZV<=1. EN_MASK is ignored. STEP=0.
  - S≥N (N not a power of 2): Z<=0, ZV<=0, ZSEL<=S.
- SCAN:
  - CNT increments each cycle.
  - When CNT≥DWELL, CNT<=0 and ZSEL<=next enabled channel, searching circularly from ZSEL+1 with wrap from N-1 to 0.
  - Z<=I[new ZSEL], ZV<=1.
- STEP=1 only when the new ZSEL differs from the old one. With a single enabled channel, ZSEL holds, CNT reloads, and STEP stays 0.
- Current channel masked off mid-dwell: advance on the next edge regardless of CNT; CNT<=0.
- DWELL changed mid-dwell: the comparison uses the new value, so CNT≥new DWELL advances immediately.
- Entry MANUAL->SCAN or IDLE->SCAN: ZSEL<=ZSEL if that channel is enabled, else the next enabled channel. CNT<=0. STEP follows the change rule.
- Entry into IDLE: ZV<=0. Z and ZSEL hold. CNT<=0.
- SCAN->MANUAL: the next edge follows S. CNT<=0.

## Timing
- Latency is 1 cycle from I/S to Z/ZSEL/ZV. All outputs are registered.
- Auto-mode channel period is DWELL+1 cycles. DWELL=0 advances every cycle.
- STEP is asserted in the same cycle ZSEL shows the new channel.
- MODE, EN_MASK and DWELL are sampled every edge. There is no handshake; changes take effect on the next edge.

## Structure
- Package ch3_scan_mux_pkg holds:
  - state enum {IDLE, MANUAL, SCAN}
  - constants MODE_MANUAL=0, MODE_AUTO=1
  - function for SEL_W derivation
- Sub-module ch3_scan_pick is combinational. It takes N-bit mask and a start index, and returns the next enabled index at or after start (circular) plus a found flag.
- Top-level content: FSM, dwell counter, and output registers.

## Test plan
- Reset mid-scan: assert RST asynchronously between edges -> Z=0, ZSEL=0, ZV=0, STEP=0 immediately, without waiting for CLK.
- Manual, N=4, W=1, I=4'b1010, S stepping 0,1,2,3 -> Z one cycle later is 0,1,0,1; ZSEL follows S; ZV=1.
- Auto, EN_MASK=4'b1111, DWELL=2 -> ZSEL sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; STEP on each change, including wrap 3->0.
- Auto, EN_MASK=4'b1010, DWELL=0 -> ZSEL alternates 1,3,1,3 every cycle. Clear bit 3 mid-run -> ZSEL stays 1 and STEP=0.
- Auto, EN_MASK=0 -> ZV=0 and Z holds. Set EN_MASK=4'b0100 -> next edge ZSEL=2, ZV=1, STEP=1.
- N=3: manual S=3 -> Z=0, ZV=0. Auto DWELL changed 7->1 when CNT=4 -> advance on the next edge.

Source files
------------

// File: rtl/ch3_scan_mux_pkg.sv
// ch3_scan_mux_pkg: shared state encoding, mode constants and select-width helper.
package ch3_scan_mux_pkg;
    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_e;
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_AUTO   = 1'b1;
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ch3_scan_mux_if.sv
// ch3_scan_mux_if: lane data, control inputs and tagged output sample of the scan mux.
interface ch3_scan_mux_if import ch3_scan_mux_pkg::*; #(
    parameter int N       = 4,
    parameter int W       = 1,
    parameter int DWELL_W = 4,
    parameter int SEL_W   = sel_w(N)
);
    logic [N*W-1:0]     I;
    logic [SEL_W-1:0]   S;
    logic               MODE;
    logic [N-1:0]       EN_MASK;
    logic [DWELL_W-1:0] DWELL;
    logic [W-1:0]       Z;
    logic [SEL_W-1:0]   ZSEL;
    logic               ZV;
    logic               STEP;
    modport master (output I, S, MODE, EN_MASK, DWELL, input Z, ZSEL, ZV, STEP);
    modport slave  (input I, S, MODE, EN_MASK, DWELL, output Z, ZSEL, ZV, STEP);
endinterface

// File: rtl/ch3_scan_pick.sv
// ch3_scan_pick: first enabled channel at or after start, searching circularly.
module ch3_scan_pick import ch3_scan_mux_pkg::*; #(
    parameter int N     = 4,
    parameter int SEL_W = sel_w(N)
) (
    input  logic [N-1:0]     mask_i,
    input  logic [SEL_W-1:0] start_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             found_o
);
    int c;
    // Walk offsets downward so the nearest enabled channel is written last.
    always_comb begin
        idx_o   = start_i;
        found_o = 1'b0;
        c       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(start_i) + k) % N;
            if (mask_i[c]) begin
                idx_o   = SEL_W'(c);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ch3_scan_mux.sv
// ch3_scan_mux: N-lane registered mux with manual select and masked round-robin auto-scan.
module ch3_scan_mux import ch3_scan_mux_pkg::*; #(
    parameter int N       = 4,
    parameter int W       = 1,
    parameter int DWELL_W = 4,
    parameter int SEL_W   = sel_w(N)
) (
    input logic            CLK,
    input logic            RST,
    ch3_scan_mux_if.slave  bus
);
    localparam int NP = 1 << SEL_W;
    state_e             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   zsel_q, zsel_d, start, pick_idx;
    logic [W-1:0]       z_q, z_d, ch_data;
    logic               zv_q, zv_d, step_q, step_d, hold, hit, found;
    logic [NP-1:0]      mask_x;
    // Padded mask so an out-of-range ZSEL left over from manual mode reads as disabled.
    assign mask_x = NP'(bus.EN_MASK);
    assign start  = (state_q == SCAN) ? zsel_q + 1'b1 : zsel_q;
    ch3_scan_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .mask_i  (bus.EN_MASK),
        .start_i (start),
        .idx_o   (pick_idx),
        .found_o (found)
    );
    always_comb begin
        state_d = (bus.MODE == MODE_MANUAL) ? MANUAL :
                  (bus.MODE == MODE_AUTO && |bus.EN_MASK) ? SCAN : IDLE;
        hold    = (state_q == SCAN) && mask_x[zsel_q] && (cnt_q < bus.DWELL);
        zsel_d  = (state_d == MANUAL) ? bus.S :
                  (state_d == SCAN && !hold && found) ? pick_idx : zsel_q;
        cnt_d   = (state_d == SCAN && hold) ? cnt_q + 1'b1 : '0;
        ch_data = '0;
        hit     = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (zsel_d == SEL_W'(k)) begin
                ch_data = bus.I[k*W +: W];
                hit     = 1'b1;
            end
        end
        z_d    = (state_d == IDLE) ? z_q : ch_data;
        zv_d   = (state_d != IDLE) && hit;
        step_d = (state_d == SCAN) && (zsel_d != zsel_q);
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            zsel_q  <= '0;
            z_q     <= '0;
            zv_q    <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zsel_q  <= zsel_d;
            z_q     <= z_d;
            zv_q    <= zv_d;
            step_q  <= step_d;
        end
    end
    assign bus.Z    = z_q;
    assign bus.ZSEL = zsel_q;
    assign bus.ZV   = zv_q;
    assign bus.STEP = step_q;
endmodule
